// File: rtl/bkm68x_mode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : bkm68x_mode_ctrl
//  Purpose  : Register-mapped monitor mode controller. A change of the
//             HD/RGB/INT mode bits runs a blank -> apply -> settle -> done
//             sequence. Video output is held off while the sequence runs.
//             A VIDEO_EN-only change takes effect immediately.
//  Options  : define BKM_MODE_IRQ_EN to build the IRQ_EN / IRQ_PEND
//             interrupt logic. Without it irq_req is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module bkm68x_mode_ctrl #(
  parameter int BLANK_CYCLES  = 200,
  parameter int SETTLE_CYCLES = 2000
) (
  input  logic       clk_20mhz,
  input  logic       reset_x,
  input  logic       wr_stb,
  input  logic       rd_stb,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       irq_req,
  input  logic       irq_ack,
  output logic       hd_sd_x,
  output logic       rgb_comp_x,
  output logic       int_ext_x,
  output logic       video_oe_x
);

  // One counter serves both timed states, so size it for the longer one.
  localparam int c_MAX_CYCLES = (BLANK_CYCLES > SETTLE_CYCLES) ? BLANK_CYCLES : SETTLE_CYCLES;
  localparam int c_CNT_W      = (c_MAX_CYCLES > 1) ? $clog2(c_MAX_CYCLES) : 1;

  localparam logic [c_CNT_W-1:0] c_BLANK_LAST  = c_CNT_W'(BLANK_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_SETTLE_LAST = c_CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE     = c_CNT_W'(1);

  localparam logic [7:0] c_ADDR_ID     = 8'h00;
  localparam logic [7:0] c_ADDR_MODE   = 8'h01;
  localparam logic [7:0] c_ADDR_STATUS = 8'h02;
  localparam logic [7:0] c_ADDR_IRQ_EN = 8'h03;
  localparam logic [7:0] c_ID_VALUE    = 8'h68;

  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_BLANK  = 3'd1;
  localparam logic [2:0] c_ST_APPLY  = 3'd2;
  localparam logic [2:0] c_ST_SETTLE = 3'd3;
  localparam logic [2:0] c_ST_DONE   = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [c_CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]         mode_q, mode_d;     // last written MODE value
  logic [2:0]         applied_q, applied_d; // mode currently driven out
  logic [7:0]         rdata_q, rdata_d;

  logic w_busy;
  logic w_wr_mode;
  logic w_wr_status;
  logic w_wr_irq_en;
  logic w_irq_en;
  logic w_irq_pend;
  logic w_unused_bits;

  assign w_busy      = (state_q != c_ST_IDLE);
  assign w_wr_mode   = wr_stb && (addr == c_ADDR_MODE);
  assign w_wr_status = wr_stb && (addr == c_ADDR_STATUS);
  assign w_wr_irq_en = wr_stb && (addr == c_ADDR_IRQ_EN);

  // MODE register next value; a write in any state simply replaces it.
  always_comb begin
    mode_d = mode_q;
    if (w_wr_mode) begin
      mode_d = wdata[3:0];
    end
  end

  // Sequencer: the comparison uses mode_d so a write landing on the
  // decision cycle is not missed.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    applied_d = applied_q;
    case (state_q)
      c_ST_IDLE: begin
        if (mode_d[2:0] != applied_q) begin
          state_d = c_ST_BLANK;
          cnt_d   = '0;
        end
      end
      c_ST_BLANK: begin
        if (cnt_q == c_BLANK_LAST) begin
          state_d = c_ST_APPLY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + c_CNT_ONE;
        end
      end
      c_ST_APPLY: begin
        applied_d = mode_d[2:0];
        state_d   = c_ST_SETTLE;
        cnt_d     = '0;
      end
      c_ST_SETTLE: begin
        if (cnt_q == c_SETTLE_LAST) begin
          state_d = c_ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + c_CNT_ONE;
        end
      end
      c_ST_DONE: begin
        cnt_d   = '0;
        state_d = (mode_d[2:0] != applied_q) ? c_ST_BLANK : c_ST_IDLE;
      end
      default: begin
        state_d = c_ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Read mux: rdata is captured on rd_stb and held until the next one.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_stb) begin
      case (addr)
        c_ADDR_ID:     rdata_d = c_ID_VALUE;
        c_ADDR_MODE:   rdata_d = {4'b0000, mode_q};
        c_ADDR_STATUS: rdata_d = {6'b000000, w_irq_pend, w_busy};
        c_ADDR_IRQ_EN: rdata_d = {7'b0000000, w_irq_en};
        default:       rdata_d = 8'h00;
      endcase
    end
  end

  // Core state registers.
  always_ff @(posedge clk_20mhz or negedge reset_x) begin
    if (!reset_x) begin
      state_q   <= c_ST_IDLE;
      cnt_q     <= '0;
      mode_q    <= 4'h0;
      applied_q <= 3'b000;
      rdata_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      applied_q <= applied_d;
      rdata_q   <= rdata_d;
    end
  end

`ifdef BKM_MODE_IRQ_EN
  logic irq_en_q;
  logic irq_pend_q;

  // Interrupt enable and pending flag; a set from DONE beats any clear.
  always_ff @(posedge clk_20mhz or negedge reset_x) begin
    if (!reset_x) begin
      irq_en_q   <= 1'b0;
      irq_pend_q <= 1'b0;
    end else begin
      if (w_wr_irq_en) begin
        irq_en_q <= wdata[0];
      end
      if ((state_q == c_ST_DONE) && irq_en_q) begin
        irq_pend_q <= 1'b1;
      end else if (irq_ack || (w_wr_status && wdata[1])) begin
        irq_pend_q <= 1'b0;
      end
    end
  end

  assign w_irq_en      = irq_en_q;
  assign w_irq_pend    = irq_pend_q;
  assign w_unused_bits = ^wdata[7:4];
`else
  assign w_irq_en      = 1'b0;
  assign w_irq_pend    = 1'b0;
  assign w_unused_bits = ^{wdata[7:4], irq_ack, w_wr_status, w_wr_irq_en};
`endif

  assign rdata      = rdata_q;
  assign irq_req    = w_irq_pend & w_irq_en;
  assign hd_sd_x    = ~applied_q[0];
  assign rgb_comp_x = ~applied_q[1];
  assign int_ext_x  = ~applied_q[2];
  assign video_oe_x = ~(mode_q[3] & ~w_busy);

endmodule
`default_nettype wire

// File: tb/tb_bkm68x_mode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bkm68x_mode_ctrl
//  Purpose  : Directed self-checking bench for bkm68x_mode_ctrl with a
//             read-data scoreboard. IRQ expectations follow BKM_MODE_IRQ_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bkm68x_mode_ctrl;

`ifdef BKM_MODE_IRQ_EN
  localparam logic c_IRQ_ON = 1'b1;
`else
  localparam logic c_IRQ_ON = 1'b0;
`endif

  logic       clk_20mhz = 1'b0;
  logic       reset_x   = 1'b0;
  logic       wr_stb    = 1'b0;
  logic       rd_stb    = 1'b0;
  logic [7:0] addr      = 8'h00;
  logic [7:0] wdata     = 8'h00;
  logic [7:0] rdata;
  logic       irq_req;
  logic       irq_ack   = 1'b0;
  logic       hd_sd_x;
  logic       rgb_comp_x;
  logic       int_ext_x;
  logic       video_oe_x;

  int checks = 0;
  int errors = 0;

  logic [7:0] sb_exp[$];
  string      sb_tag[$];

  bkm68x_mode_ctrl #(
    .BLANK_CYCLES (200),
    .SETTLE_CYCLES(2000)
  ) dut (
    .clk_20mhz (clk_20mhz),
    .reset_x   (reset_x),
    .wr_stb    (wr_stb),
    .rd_stb    (rd_stb),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .irq_req   (irq_req),
    .irq_ack   (irq_ack),
    .hd_sd_x   (hd_sd_x),
    .rgb_comp_x(rgb_comp_x),
    .int_ext_x (int_ext_x),
    .video_oe_x(video_oe_x)
  );

  always #25 clk_20mhz = ~clk_20mhz;

  task automatic tick();
    @(posedge clk_20mhz);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    wr_stb = 1'b1;
    addr   = a;
    wdata  = d;
    tick();
    wr_stb = 1'b0;
    addr   = 8'h00;
    wdata  = 8'h00;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string tag);
    rd_stb = 1'b1;
    addr   = a;
    sb_exp.push_back(exp);
    sb_tag.push_back(tag);
    tick();
    rd_stb = 1'b0;
    addr   = 8'h00;
    chk(sb_tag.pop_front(), {24'h0, rdata}, {24'h0, sb_exp.pop_front()});
  endtask

  initial begin
    int oe_low, hd_low, rgb_low, hi_cnt;

    // Reset state
    repeat (2) @(posedge clk_20mhz);
    #1;
    chk("rst_hd", hd_sd_x, 1);
    chk("rst_rgb", rgb_comp_x, 1);
    chk("rst_int", int_ext_x, 1);
    chk("rst_oe", video_oe_x, 1);
    chk("rst_irq", irq_req, 0);
    chk("rst_rdata", rdata, 8'h00);
    reset_x = 1'b1;
    tick();

    // Register map and read timing
    rd(8'h00, 8'h68, "rd_id");
    tick();
    chk("rd_hold", rdata, 8'h68);
    rd(8'h05, 8'h00, "rd_unmapped");
    rd(8'h01, 8'h00, "rd_mode_rst");
    rd(8'h02, 8'h00, "rd_status_rst");
    rd(8'h03, 8'h00, "rd_irqen_rst");

    // VIDEO_EN-only write, upper bits dropped, RO writes ignored
    wr(8'h01, 8'hF8);
    chk("oe_on_now", video_oe_x, 0);
    rd(8'h02, 8'h00, "busy_stays_0");
    rd(8'h01, 8'h08, "mode_upper_zero");
    wr(8'h00, 8'h55);
    rd(8'h00, 8'h68, "id_ro");
    wr(8'h02, 8'h01);
    rd(8'h02, 8'h00, "busy_ro");

    wr(8'h03, 8'h01);
    rd(8'h03, {7'h0, c_IRQ_ON}, "irqen_rw");

    // Full sequence 0x08 -> 0x0B, measured cycle by cycle
    wr(8'h01, 8'h0B);
    oe_low = -1; hd_low = -1; rgb_low = -1; hi_cnt = 0;
    for (int n = 0; n < 2300; n++) begin
      if (video_oe_x === 1'b1) hi_cnt++;
      if (video_oe_x === 1'b0 && oe_low < 0) oe_low = n;
      if (hd_sd_x === 1'b0 && hd_low < 0) hd_low = n;
      if (rgb_comp_x === 1'b0 && rgb_low < 0) rgb_low = n;
      tick();
    end
    chk("oe_high_cycles", hi_cnt, 2202);
    chk("oe_low_at", oe_low, 2202);
    chk("hd_low_at", hd_low, 201);
    chk("rgb_low_at", rgb_low, 201);
    chk("int_kept", int_ext_x, 1);
    chk("irq_after_done", irq_req, c_IRQ_ON);
    rd(8'h02, {6'h0, c_IRQ_ON, 1'b0}, "status_pend");
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk("irq_acked", irq_req, 0);
    rd(8'h02, 8'h00, "status_cleared");

    // irq_ack coincident with DONE: the set must win
    wr(8'h01, 8'h08);
    repeat (2201) tick();
    chk("oe_off_in_done", video_oe_x, 1);
    chk("irq_before_done", irq_req, 0);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk("irq_ack_vs_done", irq_req, c_IRQ_ON);
    chk("hd_back_high", hd_sd_x, 1);
    chk("oe_back_on", video_oe_x, 0);
    wr(8'h02, 8'h02);
    chk("irq_w1c", irq_req, 0);

    // VIDEO_EN toggle without sequence
    wr(8'h01, 8'h00);
    chk("oe_off_now", video_oe_x, 1);
    rd(8'h02, 8'h00, "no_busy_toggle");
    wr(8'h01, 8'h08);
    chk("oe_on_again", video_oe_x, 0);

    // Writes latched during SETTLE chain a second sequence straight after DONE
    wr(8'h01, 8'h0A);
    repeat (500) tick();
    wr(8'h01, 8'h09);
    wr(8'h01, 8'h0D);
    repeat (1700) tick();
    chk("first_hd", hd_sd_x, 1);
    chk("first_rgb", rgb_comp_x, 0);
    chk("first_int", int_ext_x, 1);
    chk("chain_oe", video_oe_x, 1);
    rd(8'h02, {6'h0, c_IRQ_ON, 1'b1}, "chain_busy");
    repeat (2300) tick();
    chk("final_hd", hd_sd_x, 0);
    chk("final_rgb", rgb_comp_x, 1);
    chk("final_int", int_ext_x, 0);
    chk("final_oe", video_oe_x, 0);
    chk("final_irq", irq_req, c_IRQ_ON);
    rd(8'h01, 8'h0D, "mode_latest");
    wr(8'h02, 8'h02);
    chk("irq_w1c_2", irq_req, 0);

    // Write during BLANK replaces the pending value
    wr(8'h01, 8'h08);
    repeat (50) tick();
    wr(8'h01, 8'h0E);
    repeat (2300) tick();
    chk("blank_repl_hd", hd_sd_x, 1);
    chk("blank_repl_rgb", rgb_comp_x, 0);
    chk("blank_repl_int", int_ext_x, 0);
    chk("blank_repl_oe", video_oe_x, 0);

    // Asynchronous reset in the middle of BLANK
    wr(8'h01, 8'h09);
    repeat (20) tick();
    rd(8'h00, 8'h68, "rd_before_rst");
    reset_x = 1'b0;
    #5;
    chk("arst_hd", hd_sd_x, 1);
    chk("arst_rgb", rgb_comp_x, 1);
    chk("arst_int", int_ext_x, 1);
    chk("arst_oe", video_oe_x, 1);
    chk("arst_irq", irq_req, 0);
    chk("arst_rdata", rdata, 8'h00);
    tick();
    reset_x = 1'b1;
    tick();
    rd(8'h01, 8'h00, "post_rst_mode");
    rd(8'h02, 8'h00, "post_rst_status");
    rd(8'h03, 8'h00, "post_rst_irqen");
    repeat (10) tick();
    chk("post_rst_hd", hd_sd_x, 1);
    chk("post_rst_irq", irq_req, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bkm68x_mode_ctrl.md
BKM68X_MODE_CTRL -- requirements
Module: bkm68x_mode_ctrl

Interface
REQ-001 SHALL have parameter BLANK_CYCLES, default 200: video-blank time before a mode change, in clk_20mhz cycles (10 us).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 2000: settle time after a mode change, in clk_20mhz cycles (100 us).
REQ-003 SHALL have port clk_20mhz, input, 1: the single clock for the block.
REQ-004 SHALL have port reset_x, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port wr_stb, input, 1: one-cycle register write strobe from the upstream monitor interface.
REQ-006 SHALL have port rd_stb, input, 1: one-cycle register read strobe.
REQ-007 SHALL have port addr, input, 8: register address.
REQ-008 SHALL have port wdata, input, 8: write data.
REQ-009 SHALL have port rdata, output, 8: registered read data.
REQ-010 SHALL have port irq_req, output, 1: active-high interrupt request to the monitor interface.
REQ-011 SHALL have port irq_ack, input, 1: one-cycle interrupt acknowledge.
REQ-012 SHALL have ports hd_sd_x, rgb_comp_x and int_ext_x, each output, 1: active-low mode selects (low = HD, low = RGB, low = internal sync).
REQ-013 SHALL have port video_oe_x, output, 1: active-low video output enable.

Function
REQ-014 Register map SHALL be: 0x00 ID (RO, 0x68); 0x01 MODE (RW; bit0 HD, bit1 RGB, bit2 INT, bit3 VIDEO_EN; bits 7:4 read 0); 0x02 STATUS (bit0 BUSY RO; bit1 IRQ_PEND, write-1-to-clear); 0x03 IRQ_EN (bit0, RW).
REQ-015 rdata SHALL update on the cycle after rd_stb and hold until the next rd_stb; unmapped addresses SHALL read 0x00.
REQ-016 Writes to RO bits or unmapped addresses SHALL be ignored.
REQ-017 MODE reads SHALL return the last written value, not the applied value.
REQ-018 FSM states SHALL be IDLE, BLANK, APPLY, SETTLE, DONE.
REQ-019 In IDLE, a MODE write whose bits 2:0 differ from the applied mode SHALL move the FSM to BLANK on the next cycle.
REQ-020 A MODE write changing only VIDEO_EN SHALL take effect on the next cycle without running the sequence.
REQ-021 BLANK SHALL last exactly BLANK_CYCLES cycles, then go to APPLY.
REQ-022 APPLY SHALL last 1 cycle: hd_sd_x/rgb_comp_x/int_ext_x update to the inverted MODE bits 0/1/2 at its end.
REQ-023 After APPLY, SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to DONE.
REQ-024 DONE SHALL last 1 cycle, then go to IDLE.
REQ-025 BUSY SHALL be 1 in every state except IDLE.
REQ-026 video_oe_x SHALL equal NOT(VIDEO_EN AND NOT BUSY).
REQ-027 A MODE write during BLANK SHALL replace the pending value; no restart; the latest value is applied.
REQ-028 A MODE write during SETTLE or DONE SHALL be latched; after DONE the FSM SHALL go to BLANK instead of IDLE if the latched bits 2:0 differ from the applied mode.
REQ-029 DONE SHALL set IRQ_PEND when IRQ_EN bit0 = 1; irq_req SHALL equal IRQ_PEND AND IRQ_EN bit0.
REQ-030 irq_ack or a STATUS bit1 write-1 SHALL clear IRQ_PEND; a same-cycle set from DONE SHALL win.
REQ-031 Counters SHALL be wide enough for the parameter values and SHALL NOT wrap within a state.

Reset
REQ-032 On reset_x low, asynchronously: MODE = 0x00, applied mode = 000, IRQ_EN = 0, IRQ_PEND = 0, FSM = IDLE, counters = 0, rdata = 0x00.
REQ-033 Reset outputs SHALL be: hd_sd_x = rgb_comp_x = int_ext_x = 1, video_oe_x = 1, irq_req = 0.
REQ-034 Reset mid-sequence SHALL abort the sequence with no IRQ.

Configuration
REQ-035 With macro BKM_MODE_IRQ_EN defined, REQ-029 and REQ-030 SHALL apply.
REQ-036 Without BKM_MODE_IRQ_EN: irq_req SHALL be constant 0; IRQ_EN and IRQ_PEND SHALL read 0 and ignore writes; irq_ack SHALL be ignored.

Verification
REQ-037 After reset, read 0x00 -> rdata 0x68 one cycle later; read 0x05 -> 0x00.
REQ-038 Write MODE 0x08 -> video_oe_x low next cycle; BUSY stays 0.
REQ-039 With MODE 0x08, write 0x0B -> video_oe_x high for exactly 200+1+2000+1 cycles; hd_sd_x and rgb_comp_x go low at cycle 201.
REQ-040 With IRQ_EN = 1, complete a sequence -> irq_req high after DONE; irq_ack pulse -> low; irq_ack coincident with DONE -> stays high.
REQ-041 Write 0x09 during SETTLE, then 0x0D -> second sequence runs directly after DONE; final outputs hd_sd_x = 0, rgb_comp_x = 1, int_ext_x = 0.
REQ-042 Assert reset_x mid-BLANK -> all outputs return to reset values asynchronously, irq_req = 0.
